// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the register-file write-port arbiter:
//   - default sizing for the LLU result FIFO, starvation limit and datapath
//   - grant-source encoding used by the arbiter's per-cycle decision
//   - helper that sizes the per-register pending counters
// Optional feature macro used by the arbiter: WB_ARB_SCOREBOARD_EN
// -----------------------------------------------------------------------------
package wb_arb_pkg;

    localparam int WB_ARB_DEPTH      = 4;
    localparam int WB_ARB_STARVE_MAX = 8;
    localparam int WB_ARB_DATA_W     = 32;
    localparam int WB_ARB_ADDR_W     = 5;

    // Which source owns the register-file write port this cycle.
    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_WB   = 2'd1;
    localparam logic [1:0] GNT_LLU  = 2'd2;

    // A pending counter must reach DEPTH (every FIFO entry aimed at one
    // register), so it needs one bit more than the FIFO pointer.
    function automatic int pend_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_arb_fifo.sv
// -----------------------------------------------------------------------------
// wb_arb_fifo
// Synchronous FIFO holding queued LLU results ({rd, data}) in arrival order.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   push, wdata  enqueue request and entry (ignored while full)
//   pop          dequeue request (ignored while empty)
//   head         oldest entry, valid when !empty
//   full, empty  occupancy flags derived from registered state only
// -----------------------------------------------------------------------------
module wb_arb_fifo #(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = 37
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head,
    output logic               full,
    output logic               empty
);

    localparam int              PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               do_push;
    logic               do_pop;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Next-state: storage write, pointer advance (wraps because DEPTH is a
    // power of two) and occupancy.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the single register-file write port between the pipeline writeback
// stage and a long-latency unit (mul/div). LLU results are buffered in a FIFO;
// the pipeline has priority, but once the FIFO head has been blocked for
// STARVE_MAX consecutive cycles it is forced through and the pipeline is
// stalled for one cycle (it re-presents its write next cycle).
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   wb_we, wb_rd, wb_data       pipeline writeback request
//   llu_valid/llu_ready         LLU result handshake (ready = FIFO not full)
//   llu_rd, llu_data            LLU result; rd 0 is accepted and dropped
//   wb_stall                    pipeline must hold WB this cycle
//   rf_we, rf_addr, rf_wdata    register-file write port
//   pend_vec                    registers with a queued LLU write
//                               (only when WB_ARB_SCOREBOARD_EN is defined)
// Optional feature macro: WB_ARB_SCOREBOARD_EN
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH      = WB_ARB_DEPTH,
    parameter int STARVE_MAX = WB_ARB_STARVE_MAX,
    parameter int DATA_W     = WB_ARB_DATA_W,
    parameter int ADDR_W     = WB_ARB_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_we,
    input  logic [ADDR_W-1:0]    wb_rd,
    input  logic [DATA_W-1:0]    wb_data,
    input  logic                 llu_valid,
    output logic                 llu_ready,
    input  logic [ADDR_W-1:0]    llu_rd,
    input  logic [DATA_W-1:0]    llu_data,
    output logic                 wb_stall,
    output logic                 rf_we,
    output logic [ADDR_W-1:0]    rf_addr,
    output logic [DATA_W-1:0]    rf_wdata
`ifdef WB_ARB_SCOREBOARD_EN
    ,
    output logic [2**ADDR_W-1:0] pend_vec
`endif
);

    localparam int         ENTRY_W    = ADDR_W + DATA_W;
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic [ADDR_W-1:0]  head_rd;
    logic [DATA_W-1:0]  head_data;
    logic [1:0]         gnt;
    logic               force_llu;
    logic               wb_req;
    logic [7:0]         starve_q, starve_d;

    assign head_rd   = fifo_head[ENTRY_W-1:DATA_W];
    assign head_data = fifo_head[DATA_W-1:0];

    wb_arb_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ({llu_rd, llu_data}),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Per-cycle grant: forced drain beats the pipeline, the pipeline beats a
    // normal drain. A pipeline write to x0 is not a request, so it frees the
    // port for the FIFO.
    always_comb begin
        force_llu = !fifo_empty && (starve_q == STARVE_LIM);
        wb_req    = wb_we && (wb_rd != '0);
        if (force_llu) begin
            gnt = GNT_LLU;
        end else if (wb_req) begin
            gnt = GNT_WB;
        end else if (!fifo_empty) begin
            gnt = GNT_LLU;
        end else begin
            gnt = GNT_NONE;
        end
    end

    // Handshake and write-port drive. rst gates the outputs directly so they
    // are quiet for the whole reset pulse, not just after the next edge.
    always_comb begin
        llu_ready = !rst && !fifo_full;
        fifo_push = llu_valid && llu_ready && (llu_rd != '0);
        fifo_pop  = (gnt == GNT_LLU);
        wb_stall  = !rst && force_llu;
        rf_we     = !rst && (gnt != GNT_NONE);
        case (gnt)
            GNT_LLU: begin
                rf_addr  = head_rd;
                rf_wdata = head_data;
            end
            default: begin
                rf_addr  = wb_rd;
                rf_wdata = wb_data;
            end
        endcase
    end

    // Starvation counter: counts consecutive cycles the head waits, saturating
    // at the limit so the force condition holds until the drain happens.
    always_comb begin
        if (fifo_empty || fifo_pop) begin
            starve_d = 8'd0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + 8'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= 8'd0;
        end else begin
            starve_q <= starve_d;
        end
    end

`ifdef WB_ARB_SCOREBOARD_EN
    localparam int NREG  = 2**ADDR_W;
    localparam int CNT_W = pend_cnt_w(DEPTH);

    logic [CNT_W-1:0] pend_q [NREG];
    logic [CNT_W-1:0] pend_d [NREG];

    // Pending counters: +1 on enqueue, -1 on dequeue of that rd; both in the
    // same cycle on the same register cancel out.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            logic inc;
            logic dec;
            inc = fifo_push && (llu_rd == ADDR_W'(r));
            dec = fifo_pop && (head_rd == ADDR_W'(r));
            case ({inc, dec})
                2'b10:   pend_d[r] = pend_q[r] + CNT_W'(1);
                2'b01:   pend_d[r] = pend_q[r] - CNT_W'(1);
                default: pend_d[r] = pend_q[r];
            endcase
        end
    end

    // Pending-vector decode; x0 is never reported pending.
    always_comb begin
        pend_vec = '0;
        for (int r = 1; r < NREG; r++) begin
            pend_vec[r] = (pend_q[r] != '0);
        end
    end

    // Pending counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                pend_q[r] <= '0;
            end
        end else begin
            pend_q <= pend_d;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        llu_valid;
    logic        llu_ready;
    logic [4:0]  llu_rd;
    logic [31:0] llu_data;
    logic        wb_stall;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
`ifdef WB_ARB_SCOREBOARD_EN
    logic [31:0] pend_vec;
`endif

    regfile_wb_arbiter #(
        .DEPTH      (4),
        .STARVE_MAX (8),
        .DATA_W     (32),
        .ADDR_W     (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .llu_valid (llu_valid),
        .llu_ready (llu_ready),
        .llu_rd    (llu_rd),
        .llu_data  (llu_data),
        .wb_stall  (wb_stall),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_wdata  (rf_wdata)
`ifdef WB_ARB_SCOREBOARD_EN
        ,
        .pend_vec  (pend_vec)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
        exp_q.push_back({rd, d});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every register-file write must match the oldest
    // expected write; a write with nothing expected is an error.
    always @(negedge clk) begin
        if (rf_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got we=%b x%0d=0x%0h expected no write at %0t",
                         rf_we, rf_addr, rf_wdata, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rf_addr", 32'(rf_addr), 32'(mon_e.rd));
                chk("rf_wdata", rf_wdata, mon_e.data);
            end
        end
    end

    initial begin
        rst = 1'b1; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        llu_valid = 1'b0; llu_rd = 5'd0; llu_data = 32'd0;

        // Reset state
        @(negedge clk);
        chk("reset_rf_we", 32'(rf_we), 32'd0);
        chk("reset_llu_ready", 32'(llu_ready), 32'd0);
        chk("reset_wb_stall", 32'(wb_stall), 32'd0);
        tick();
        rst = 1'b0;

        // Idle pipeline: one-cycle accept-to-write latency
        llu_valid = 1'b1; llu_rd = 5'd7; llu_data = 32'hDEAD0001;
        @(negedge clk);
        chk("idle_ready", 32'(llu_ready), 32'd1);
        chk("idle_no_same_cycle_write", 32'(rf_we), 32'd0);
        expect_wr(5'd7, 32'hDEAD0001);
        tick();
        llu_valid = 1'b0;
        @(negedge clk);
        chk("idle_latency_we", 32'(rf_we), 32'd1);
        tick();

        // Priority: pipeline write beats a queued LLU result
        llu_valid = 1'b1; llu_rd = 5'd3; llu_data = 32'h33;
        @(negedge clk);
        tick();
        llu_valid = 1'b0; wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h11;
        expect_wr(5'd5, 32'h11);
        @(negedge clk);
        chk("prio_stall", 32'(wb_stall), 32'd0);
        tick();
        wb_we = 1'b0;
        expect_wr(5'd3, 32'h33);
        @(negedge clk);
        chk("prio_drain_we", 32'(rf_we), 32'd1);
        tick();

        // Starvation: head forced through on the 9th blocked cycle, wb retried
        for (int i = 0; i <= 10; i++) begin
            wb_we = 1'b1; wb_rd = 5'd10;
            wb_data = (i == 10) ? 32'h109 : 32'(32'h100 + i);
            llu_valid = (i == 0); llu_rd = 5'd9; llu_data = 32'h99;
            if (i == 9) expect_wr(5'd9, 32'h99);
            else        expect_wr(5'd10, wb_data);
            @(negedge clk);
            chk($sformatf("starve_stall_%0d", i), 32'(wb_stall), (i == 9) ? 32'd1 : 32'd0);
            tick();
        end
        wb_we = 1'b0; llu_valid = 1'b0;
        @(negedge clk);
        tick();

        // Full FIFO: ready drops at 4 entries, LLU holds until a slot frees
        for (int i = 0; i <= 10; i++) begin
            wb_we = 1'b1; wb_rd = 5'd12;
            wb_data = (i == 10) ? 32'h209 : 32'(32'h200 + i);
            llu_valid = 1'b1;
            if (i < 4) begin
                llu_rd = 5'(20 + i); llu_data = 32'(32'h400 + i);
            end else begin
                llu_rd = 5'd24; llu_data = 32'h404;
            end
            if (i == 9) expect_wr(5'd20, 32'h400);
            else        expect_wr(5'd12, wb_data);
            @(negedge clk);
            chk($sformatf("full_ready_%0d", i), 32'(llu_ready),
                ((i < 4) || (i == 10)) ? 32'd1 : 32'd0);
            chk($sformatf("full_stall_%0d", i), 32'(wb_stall), (i == 9) ? 32'd1 : 32'd0);
            tick();
        end
        wb_we = 1'b0; llu_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_wr(5'(21 + i), 32'(32'h401 + i));
            @(negedge clk);
            chk($sformatf("full_drain_we_%0d", i), 32'(rf_we), 32'd1);
            tick();
        end

        // x0 handling: LLU rd 0 dropped; wb_rd 0 frees the port for the FIFO
        llu_valid = 1'b1; llu_rd = 5'd0; llu_data = 32'hBAD;
        @(negedge clk);
        chk("x0_ready", 32'(llu_ready), 32'd1);
        tick();
        llu_valid = 1'b0;
        @(negedge clk);
        chk("x0_llu_not_written", 32'(rf_we), 32'd0);
        tick();
        llu_valid = 1'b1; llu_rd = 5'd6; llu_data = 32'h66;
        @(negedge clk);
        tick();
        llu_valid = 1'b0; wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h77;
        expect_wr(5'd6, 32'h66);
        @(negedge clk);
        chk("x0_wb_frees_port_we", 32'(rf_we), 32'd1);
        chk("x0_wb_frees_port_addr", 32'(rf_addr), 32'd6);
        tick();
        wb_we = 1'b0;
        @(negedge clk);
        chk("x0_after_idle", 32'(rf_we), 32'd0);
        tick();

        // Reset mid-operation with three entries queued
        for (int i = 0; i < 3; i++) begin
            wb_we = 1'b1; wb_rd = 5'd11; wb_data = 32'(32'h300 + i);
            llu_valid = 1'b1; llu_rd = 5'(13 + i); llu_data = 32'(32'h500 + i);
            expect_wr(5'd11, wb_data);
            @(negedge clk);
            tick();
        end
`ifdef WB_ARB_SCOREBOARD_EN
        chk("pend_before_rst", pend_vec, 32'h0000_E000);
`endif
        llu_valid = 1'b0; wb_data = 32'h303; rst = 1'b1;
        @(negedge clk);
        chk("midrst_rf_we", 32'(rf_we), 32'd0);
        chk("midrst_llu_ready", 32'(llu_ready), 32'd0);
        chk("midrst_wb_stall", 32'(wb_stall), 32'd0);
        tick();
        rst = 1'b0; wb_we = 1'b0;
        @(negedge clk);
        chk("postrst_llu_ready", 32'(llu_ready), 32'd1);
        chk("postrst_empty", 32'(rf_we), 32'd0);
`ifdef WB_ARB_SCOREBOARD_EN
        chk("postrst_pend_vec", pend_vec, 32'd0);
`endif
        tick();
        @(negedge clk);
        chk("postrst_still_empty", 32'(rf_we), 32'd0);
        tick();

        chk("all_writes_seen", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
